// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight writes per destination register,
// publishes the pending-destination mask for RAW stalls and blocks issue
// after a flush until every outstanding write has retired.
module reg_scoreboard #(
    parameter int CNT_W   = 2,
    parameter int TOTAL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               issue_valid,
    input  logic [4:0]         issue_rd,
    output logic               issue_ready,
    input  logic               wb_valid,
    input  logic [4:0]         wb_rd,
    output logic [31:0]        pending_mask,
    output logic [TOTAL_W-1:0] outstanding,
    output logic               draining,
    output logic               underflow_err
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [TOTAL_W-1:0] TOTAL_MAX = {TOTAL_W{1'b1}};

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [32];
    logic [CNT_W-1:0]   cnt_d [32];
    logic [31:0]        mask_q, mask_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic               underflow_q, underflow_d;

    logic accept;
    logic wb_hit;
    logic same_rd_issue;
    logic wb_retires;

    // Issue gating and the global retire/underflow decisions. Register x0
    // never counts: rd=0 is filtered out of both accept and wb_hit.
    always_comb begin
        issue_ready   = (state_q == RUN) && !flush &&
                        (cnt_q[issue_rd] != CNT_MAX) && (total_q != TOTAL_MAX);
        accept        = issue_valid && issue_ready && (issue_rd != 5'd0);
        wb_hit        = wb_valid && (wb_rd != 5'd0);
        same_rd_issue = accept && (issue_rd == wb_rd);
        // A writeback to an idle register is only legal if it pairs with a
        // same-cycle issue to that register (it retires the new write).
        wb_retires    = wb_hit && ((cnt_q[wb_rd] != '0) || same_rd_issue);
        underflow_d   = underflow_q || (wb_hit && !wb_retires);

        total_d = total_q;
        if (accept && !wb_retires) begin
            total_d = total_q + TOTAL_W'(1);
        end else if (!accept && wb_retires) begin
            total_d = total_q - TOTAL_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_cnt
            logic inc;
            logic dec;

            // Per-register next count; simultaneous issue and retire cancel.
            always_comb begin
                inc = accept && (issue_rd == 5'(gi));
                dec = wb_retires && (wb_rd == 5'(gi));
                cnt_d[gi] = cnt_q[gi];
                if (inc && !dec) begin
                    cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
                end else if (!inc && dec) begin
                    cnt_d[gi] = cnt_q[gi] - CNT_W'(1);
                end
                mask_d[gi] = (gi != 0) && (cnt_d[gi] != '0);
            end

            // Per-register pending counter.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q[gi] <= '0;
                end else begin
                    cnt_q[gi] <= cnt_d[gi];
                end
            end
        end
    endgenerate

    // Flush recovery: leave DRAIN once the last outstanding write is gone.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (!flush && (total_d == '0)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Global state, outstanding count, registered mask and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            total_q     <= '0;
            mask_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            mask_q      <= mask_d;
            underflow_q <= underflow_d;
        end
    end

    assign pending_mask  = mask_q;
    assign outstanding   = total_q;
    assign draining      = (state_q == DRAIN);
    assign underflow_err = underflow_q;

endmodule
